// File: rtl/cpu_pkg.sv
// Shared CPU register-file types: data width, select width and derived register count.
package cpu_pkg;

   localparam int N        = 16;
   localparam int SEL_LINE = 4;
   localparam int NREG     = 2 ** SEL_LINE;

   typedef logic [SEL_LINE-1:0] reg_idx_t;
   typedef logic [N-1:0]        word_t;

endpackage

// File: rtl/src_reg_read_if.sv
// Issue/writeback/operand bundle of the register-file read side.
// master = issue and writeback producers, slave = the register file.
interface src_reg_read_if;
   import cpu_pkg::*;

   logic     wr_en;
   reg_idx_t rd_sel;
   word_t    rd_val;
   logic     busy_set;
   reg_idx_t busy_sel;
   logic     req_valid;
   logic     req_ready;
   reg_idx_t rs1_sel;
   reg_idx_t rs2_sel;
   logic     out_valid;
   word_t    rs1_val;
   word_t    rs2_val;

   modport master (
      output wr_en, rd_sel, rd_val, busy_set, busy_sel,
      output req_valid, rs1_sel, rs2_sel,
      input  req_ready, out_valid, rs1_val, rs2_val
   );

   modport slave (
      input  wr_en, rd_sel, rd_val, busy_set, busy_sel,
      input  req_valid, rs1_sel, rs2_sel,
      output req_ready, out_valid, rs1_val, rs2_val
   );

endinterface

// File: rtl/src_mux.sv
// Combinational register read mux; a same-cycle writeback to the selected index
// overrides the stored value.
module src_mux
   import cpu_pkg::*;
(
   input  word_t    i_regs [NREG],
   input  reg_idx_t i_sel,
   input  logic     i_wr_en,
   input  reg_idx_t i_rd_sel,
   input  word_t    i_rd_val,
   output word_t    o_val
);

   logic w_fwd;

   assign w_fwd = i_wr_en && (i_rd_sel == i_sel);
   assign o_val = w_fwd ? i_rd_val : i_regs[i_sel];

endmodule

// File: rtl/src_reg_read.sv
// Register file source-read side: 16 registers, busy scoreboard, forwarded
// dual operand read with a one-cycle registered result.
module src_reg_read
   import cpu_pkg::*;
(
   input logic           clk,
   input logic           rst,
   src_reg_read_if.slave bus
);

   word_t            r_regs [NREG];
   logic [NREG-1:0]  r_busy;
   logic             r_out_valid;
   word_t            r_rs1_val;
   word_t            r_rs2_val;

   logic [NREG-1:0]  w_wr_hit;
   logic [NREG-1:0]  w_busy_next;
   logic             w_fwd1;
   logic             w_fwd2;
   logic             w_haz1;
   logic             w_haz2;
   logic             w_ready;
   logic             w_accept;
   word_t            w_rs1_mux;
   word_t            w_rs2_mux;

   // A busy_set on the same index as a writeback wins: the new producer supersedes.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
         assign w_wr_hit[gi]    = bus.wr_en && (bus.rd_sel == reg_idx_t'(gi));
         assign w_busy_next[gi] = (bus.busy_set && (bus.busy_sel == reg_idx_t'(gi))) ? 1'b1 :
                                  w_wr_hit[gi] ? 1'b0 : r_busy[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
         r_busy <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (w_wr_hit[i]) r_regs[i] <= bus.rd_val;
         end
         r_busy <= w_busy_next;
      end
   end

   // The writeback that clears a busy register also forwards, so it is not a hazard.
   assign w_fwd1   = bus.wr_en && (bus.rd_sel == bus.rs1_sel);
   assign w_fwd2   = bus.wr_en && (bus.rd_sel == bus.rs2_sel);
   assign w_haz1   = r_busy[bus.rs1_sel] && !w_fwd1;
   assign w_haz2   = r_busy[bus.rs2_sel] && !w_fwd2;
   assign w_ready  = !w_haz1 && !w_haz2;
   assign w_accept = bus.req_valid && w_ready;

   src_mux u_mux_rs1 (
      .i_regs   (r_regs),
      .i_sel    (bus.rs1_sel),
      .i_wr_en  (bus.wr_en),
      .i_rd_sel (bus.rd_sel),
      .i_rd_val (bus.rd_val),
      .o_val    (w_rs1_mux)
   );

   src_mux u_mux_rs2 (
      .i_regs   (r_regs),
      .i_sel    (bus.rs2_sel),
      .i_wr_en  (bus.wr_en),
      .i_rd_sel (bus.rd_sel),
      .i_rd_val (bus.rd_val),
      .o_val    (w_rs2_mux)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_rs1_val   <= '0;
         r_rs2_val   <= '0;
      end else begin
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_rs1_val <= w_rs1_mux;
            r_rs2_val <= w_rs2_mux;
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.rs1_val   = r_rs1_val;
   assign bus.rs2_val   = r_rs2_val;

endmodule

// File: tb/tb_src_reg_read.sv
// Bench for src_reg_read: directed vector table, reset sequence and a
// randomized phase checked against a reference model through a scoreboard.
module tb_src_reg_read;
   import cpu_pkg::*;

   typedef struct {
      logic     wr;
      reg_idx_t rd;
      word_t    rdv;
      logic     bs;
      reg_idx_t bsel;
      logic     rv;
      reg_idx_t s1;
      reg_idx_t s2;
      logic     er;
      word_t    e1;
      word_t    e2;
   } vec_t;

   typedef struct {
      word_t v1;
      word_t v2;
   } exp_t;

   logic clk;
   logic rst;
   src_reg_read_if bus ();

   src_reg_read dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   int    txn    = 0;
   exp_t  sb [$];
   word_t last1 = '0;
   word_t last2 = '0;
   word_t m_regs [NREG];
   logic  m_busy [NREG];
   vec_t  tbl [19];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endfunction

   // One clock cycle: drive, check ready, predict, clock, check output.
   task automatic step(input vec_t v, input bit use_tbl);
      logic  e_ready;
      word_t e1;
      word_t e2;
      bit    acc;
      exp_t  e;
      bus.wr_en     = v.wr;
      bus.rd_sel    = v.rd;
      bus.rd_val    = v.rdv;
      bus.busy_set  = v.bs;
      bus.busy_sel  = v.bsel;
      bus.req_valid = v.rv;
      bus.rs1_sel   = v.s1;
      bus.rs2_sel   = v.s2;
      #2;
      e_ready = !(m_busy[v.s1] && !(v.wr && v.rd == v.s1)) &&
                !(m_busy[v.s2] && !(v.wr && v.rd == v.s2));
      e1 = (v.wr && v.rd == v.s1) ? v.rdv : m_regs[v.s1];
      e2 = (v.wr && v.rd == v.s2) ? v.rdv : m_regs[v.s2];
      if (use_tbl) begin
         e_ready = v.er;
         e1      = v.e1;
         e2      = v.e2;
      end
      chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
      acc = v.rv && e_ready;
      if (acc) begin
         e.v1 = e1;
         e.v2 = e2;
         sb.push_back(e);
      end
      if (v.wr) begin
         m_regs[v.rd] = v.rdv;
         m_busy[v.rd] = 1'b0;
      end
      if (v.bs) m_busy[v.bsel] = 1'b1;
      @(posedge clk);
      #1;
      chk("out_valid", 32'(bus.out_valid), 32'(acc));
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            txn++;
            $display("txn %0d rs1=%h (exp %h) rs2=%h (exp %h)",
                     txn, bus.rs1_val, e.v1, bus.rs2_val, e.v2);
            chk("rs1_val", 32'(bus.rs1_val), 32'(e.v1));
            chk("rs2_val", 32'(bus.rs2_val), 32'(e.v2));
            last1 = e.v1;
            last2 = e.v2;
         end
      end else begin
         chk("rs1_hold", 32'(bus.rs1_val), 32'(last1));
         chk("rs2_hold", 32'(bus.rs2_val), 32'(last2));
      end
   endtask

   initial begin
      vec_t v;
      // wr rd rdv bs bsel rv s1 s2 | ready exp1 exp2
      tbl[0]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd3, 4'd15, 1'b1, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b1, 4'd5, 16'hA5A5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0,  1'b1, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd5, 4'd0,  1'b1, 16'hA5A5, 16'h0000};
      tbl[3]  = '{1'b1, 4'd7, 16'h1234, 1'b0, 4'd0, 1'b1, 4'd7, 4'd7,  1'b1, 16'h1234, 16'h1234};
      tbl[4]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 1'b0, 4'd0, 4'd0,  1'b1, 16'h0000, 16'h0000};
      tbl[5]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd0, 4'd9,  1'b0, 16'h0000, 16'h0000};
      tbl[6]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd0, 4'd9,  1'b0, 16'h0000, 16'h0000};
      tbl[7]  = '{1'b1, 4'd9, 16'h00FF, 1'b0, 4'd0, 1'b1, 4'd0, 4'd9,  1'b1, 16'h0000, 16'h00FF};
      tbl[8]  = '{1'b1, 4'd2, 16'h0042, 1'b1, 4'd2, 1'b0, 4'd0, 4'd0,  1'b1, 16'h0000, 16'h0000};
      tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd2, 4'd0,  1'b0, 16'h0000, 16'h0000};
      tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd2, 4'd0,  1'b0, 16'h0000, 16'h0000};
      tbl[11] = '{1'b1, 4'd2, 16'h0043, 1'b0, 4'd0, 1'b1, 4'd2, 4'd0,  1'b1, 16'h0043, 16'h0000};
      tbl[12] = '{1'b1, 4'd4, 16'h0011, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0,  1'b1, 16'h0000, 16'h0000};
      tbl[13] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 1'b1, 4'd4, 4'd5,  1'b1, 16'h0011, 16'hA5A5};
      tbl[14] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd4, 4'd5,  1'b0, 16'h0000, 16'h0000};
      tbl[15] = '{1'b1, 4'd4, 16'h0022, 1'b0, 4'd0, 1'b1, 4'd4, 4'd4,  1'b1, 16'h0022, 16'h0022};
      tbl[16] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd9, 4'd2,  1'b1, 16'h00FF, 16'h0043};
      tbl[17] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd7, 4'd5,  1'b1, 16'h1234, 16'hA5A5};
      tbl[18] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd10, 1'b1, 4'd5, 4'd7, 1'b1, 16'hA5A5, 16'h1234};

      rst           = 1'b1;
      bus.wr_en     = 1'b0;
      bus.rd_sel    = '0;
      bus.rd_val    = '0;
      bus.busy_set  = 1'b0;
      bus.busy_sel  = '0;
      bus.req_valid = 1'b0;
      bus.rs1_sel   = '0;
      bus.rs2_sel   = '0;
      model_clear();
      #1;
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_rs1", 32'(bus.rs1_val), 32'd0);
      chk("reset_rs2", 32'(bus.rs2_val), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 19; i++) step(tbl[i], 1'b1);

      // Asynchronous reset right after an accept: result discarded, state cleared.
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_rs1", 32'(bus.rs1_val), 32'd0);
      chk("midrst_rs2", 32'(bus.rs2_val), 32'd0);
      model_clear();
      sb.delete();
      last1 = '0;
      last2 = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      v = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd3, 4'd15, 1'b1, 16'h0000, 16'h0000};
      step(v, 1'b1);
      v = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd10, 4'd5, 1'b1, 16'h0000, 16'h0000};
      step(v, 1'b1);

      for (int i = 0; i < 400; i++) begin
         v.wr   = ($urandom_range(9) < 4);
         v.rd   = reg_idx_t'($urandom_range(NREG - 1));
         v.rdv  = word_t'($urandom);
         v.bs   = ($urandom_range(9) < 3);
         v.bsel = reg_idx_t'($urandom_range(NREG - 1));
         v.rv   = ($urandom_range(9) < 7);
         v.s1   = reg_idx_t'($urandom_range(NREG - 1));
         v.s2   = reg_idx_t'($urandom_range(NREG - 1));
         v.er   = 1'b0;
         v.e1   = '0;
         v.e2   = '0;
         step(v, 1'b0);
      end

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
